// File: rtl/uart_sim_pkg.sv
// Package: uart_sim_pkg
// Purpose: Shared character type and the "no character" code used by the
//          UART input feeder and the UART output console logic.
// Contents:
//   uart_char_t   - one 8-bit UART character
//   UART_CH_NONE  - value returned to a getc request when nothing is available
package uart_sim_pkg;

    typedef logic [7:0] uart_char_t;

    localparam uart_char_t UART_CH_NONE = 8'hFF;

endpackage

// File: rtl/uart_char_fifo.sv
// Module: uart_char_fifo
// Purpose: Character FIFO used by uart_in_feeder. It holds the storage,
//          the read/write pointers and the occupancy count.
//          Full and empty are decided by the level, not by the pointers.
//          The pointers wrap naturally.
// Parameters:
//   DEPTH    - number of entries; must be a power of two, >= 2
// Ports:
//   clock    in   1                 system clock
//   reset    in   1                 synchronous, active-high; empties the FIFO
//   push     in   1                 write push_ch this cycle (ignored when full)
//   push_ch  in   8                 byte to write
//   pop      in   1                 advance the read pointer (ignored when empty)
//   head_ch  out  8                 byte at the read pointer
//   level    out  $clog2(DEPTH)+1   occupancy
//   full     out  1                 level == DEPTH
module uart_char_fifo
    import uart_sim_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_ch,
    input  logic                     pop,
    output logic [7:0]               head_ch,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    uart_char_t        mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == LW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (level != '0);
    assign head_ch = mem[rd_ptr];

    // Storage holds data only, so it is left out of reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_ch;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_in_feeder.sv
// Module: uart_in_feeder
// Purpose: Character source for the SimTop UART input port. The host pushes
//          bytes into a FIFO. Each getc request (io_uart_in_valid) gets the
//          FIFO head in the same cycle and pops it. When no character is
//          deliverable, the request gets 8'hFF and is counted as a starve.
//          An optional gap of GAP idle cycles after every delivered character
//          models a slow line.
// Optional feature: define UART_IN_ECHO_EN to add echo_valid/echo_ch. These
//          are a registered copy of every pop, shown one cycle after the pop,
//          so typed input appears in the console log.
// Parameters:
//   DEPTH  - FIFO entries (power of two, >= 2)
//   GAP    - idle cycles after each delivered char; 0 = back-to-back
//   CW     - starve counter width
// Ports:
//   clock             in   1                 system clock
//   reset             in   1                 synchronous, active-high
//   host_valid        in   1                 host offers host_ch
//   host_ch           in   8                 byte to enqueue
//   host_ready        out  1                 FIFO can accept this cycle
//   io_uart_in_valid  in   1                 getc request
//   io_uart_in_ch     out  8                 returned byte (combinational)
//   level             out  $clog2(DEPTH)+1   FIFO occupancy
//   starve_cnt        out  CW                requests answered with 8'hFF
//   echo_valid        out  1                 [UART_IN_ECHO_EN] delivered-char strobe
//   echo_ch           out  8                 [UART_IN_ECHO_EN] delivered char
module uart_in_feeder
    import uart_sim_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int GAP   = 0,
    parameter int CW    = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     host_valid,
    input  logic [7:0]               host_ch,
    output logic                     host_ready,
    input  logic                     io_uart_in_valid,
    output logic [7:0]               io_uart_in_ch,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CW-1:0]            starve_cnt
`ifdef UART_IN_ECHO_EN
    ,
    output logic                     echo_valid,
    output logic [7:0]               echo_ch
`endif
);

    // The gap counter needs at least one bit, even when GAP is 0.
    localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);

    logic            fifo_full;
    uart_char_t      head_ch;
    logic [GW-1:0]   gap_cnt;
    logic            deliverable;
    logic            push;
    logic            pop;
    logic            starve;

    assign deliverable   = (level != '0) && (gap_cnt == '0);
    assign pop           = io_uart_in_valid && deliverable;
    assign starve        = io_uart_in_valid && !deliverable;
    // Ready depends only on the registered level. A pop in this cycle
    // does not free a slot until the next cycle.
    assign host_ready    = !fifo_full;
    assign push          = host_valid && host_ready;
    assign io_uart_in_ch = deliverable ? head_ch : UART_CH_NONE;

    uart_char_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .push_ch (host_ch),
        .pop     (pop),
        .head_ch (head_ch),
        .level   (level),
        .full    (fifo_full)
    );

    // Pop and a nonzero gap_cnt cannot happen together, because a pop needs
    // gap_cnt == 0. Loading on pop therefore never conflicts with the
    // decrement.
    always_ff @(posedge clock) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if (pop) begin
            gap_cnt <= GW'(GAP);
        end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    // The starve counter saturates at all-ones and never wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (starve && (starve_cnt != '1)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

`ifdef UART_IN_ECHO_EN
    logic            echo_vld_p1;
    uart_char_t      echo_ch_p1;

    // ---- stage p1: pop registered for the console echo path ----
    always_ff @(posedge clock) begin
        if (reset) begin
            echo_vld_p1 <= 1'b0;
        end else begin
            echo_vld_p1 <= pop;
        end
    end

    always_ff @(posedge clock) begin
        if (pop) begin
            echo_ch_p1 <= head_ch;
        end
    end

    assign echo_valid = echo_vld_p1;
    assign echo_ch    = echo_ch_p1;
`endif

endmodule

// File: tb/tb_uart_in_feeder.sv
module tb_uart_in_feeder;

    logic        clock;
    logic        reset;

    // Instance a: DEPTH=16, GAP=0, CW=32
    logic        a_host_valid;
    logic [7:0]  a_host_ch;
    logic        a_host_ready;
    logic        a_uart_valid;
    logic [7:0]  a_uart_ch;
    logic [4:0]  a_level;
    logic [31:0] a_starve;

    // Instance b: DEPTH=4, GAP=2, CW=2 (gap timing and counter saturation)
    logic        b_host_valid;
    logic [7:0]  b_host_ch;
    logic        b_host_ready;
    logic        b_uart_valid;
    logic [7:0]  b_uart_ch;
    logic [2:0]  b_level;
    logic [1:0]  b_starve;

`ifdef UART_IN_ECHO_EN
    logic        a_echo_valid;
    logic [7:0]  a_echo_ch;
    logic        b_echo_valid;
    logic [7:0]  b_echo_ch;
`endif

    int n_pass;
    int n_total;

    uart_in_feeder #(.DEPTH(16), .GAP(0), .CW(32)) u_a (
        .clock            (clock),
        .reset            (reset),
        .host_valid       (a_host_valid),
        .host_ch          (a_host_ch),
        .host_ready       (a_host_ready),
        .io_uart_in_valid (a_uart_valid),
        .io_uart_in_ch    (a_uart_ch),
        .level            (a_level),
        .starve_cnt       (a_starve)
`ifdef UART_IN_ECHO_EN
        ,
        .echo_valid       (a_echo_valid),
        .echo_ch          (a_echo_ch)
`endif
    );

    uart_in_feeder #(.DEPTH(4), .GAP(2), .CW(2)) u_b (
        .clock            (clock),
        .reset            (reset),
        .host_valid       (b_host_valid),
        .host_ch          (b_host_ch),
        .host_ready       (b_host_ready),
        .io_uart_in_valid (b_uart_valid),
        .io_uart_in_ch    (b_uart_ch),
        .level            (b_level),
        .starve_cnt       (b_starve)
`ifdef UART_IN_ECHO_EN
        ,
        .echo_valid       (b_echo_valid),
        .echo_ch          (b_echo_ch)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic a_push(input logic [7:0] ch);
        a_host_valid = 1'b1;
        a_host_ch    = ch;
        tick();
        a_host_valid = 1'b0;
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        reset        = 1'b1;
        a_host_valid = 1'b0;
        a_host_ch    = 8'h00;
        a_uart_valid = 1'b0;
        b_host_valid = 1'b0;
        b_host_ch    = 8'h00;
        b_uart_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_level",  32'(a_level), 0);
        check("rst_starve", a_starve, 0);
        check("rst_ready",  32'(a_host_ready), 1);
        check("rst_ch",     32'(a_uart_ch), 32'hFF);
`ifdef UART_IN_ECHO_EN
        check("rst_echo_valid", 32'(a_echo_valid), 0);
`endif

        // Test 1: three requests on an empty FIFO
        a_uart_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t1_ch", 32'(a_uart_ch), 32'hFF);
            tick();
        end
        a_uart_valid = 1'b0;
        check("t1_starve", a_starve, 3);
        check("t1_level",  32'(a_level), 0);

        do_reset();
        check("t1_rst_starve", a_starve, 0);

        // Test 2: "ABC" delivered in order
        a_push(8'h41);
        a_push(8'h42);
        a_push(8'h43);
        check("t2_level3", 32'(a_level), 3);
        a_uart_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_ch", 32'(a_uart_ch), 32'h41 + i);
            tick();
            check("t2_level", 32'(a_level), 2 - i);
`ifdef UART_IN_ECHO_EN
            check("t2_echo_valid", 32'(a_echo_valid), 1);
            check("t2_echo_ch",    32'(a_echo_ch), 32'h41 + i);
`endif
        end
        a_uart_valid = 1'b0;
        check("t2_starve", a_starve, 0);
`ifdef UART_IN_ECHO_EN
        tick();
        check("t2_echo_off", 32'(a_echo_valid), 0);
`endif

        // Test 3: 17 pushes with host_valid held into a 16-deep FIFO
        a_host_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_host_ch = 8'h10 + 8'(i);
            #1;
            check("t3_ready_fill", 32'(a_host_ready), 1);
            tick();
        end
        a_host_ch = 8'h20;
        check("t3_level16", 32'(a_level), 16);
        check("t3_ready_low", 32'(a_host_ready), 0);
        tick();
        check("t3_hold_level", 32'(a_level), 16);
        a_uart_valid = 1'b1;
        #1;
        check("t3_pop_ch", 32'(a_uart_ch), 32'h10);
        check("t3_no_early_ready", 32'(a_host_ready), 0);
        tick();
        a_uart_valid = 1'b0;
        check("t3_level15", 32'(a_level), 15);
        check("t3_ready_back", 32'(a_host_ready), 1);
        tick();
        a_host_valid = 1'b0;
        check("t3_level16b", 32'(a_level), 16);
        check("t3_ready_low2", 32'(a_host_ready), 0);
        a_uart_valid = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            #1;
            check("t3_drain_ch", 32'(a_uart_ch), 32'h10 + i);
            tick();
        end
        a_uart_valid = 1'b0;
        check("t3_level0", 32'(a_level), 0);
        check("t3_starve", a_starve, 0);

        // Test 5: simultaneous push and pop at level 1
        a_push(8'h33);
        check("t5_level1", 32'(a_level), 1);
        a_host_valid = 1'b1;
        a_host_ch    = 8'h5A;
        a_uart_valid = 1'b1;
        #1;
        check("t5_old_head", 32'(a_uart_ch), 32'h33);
        tick();
        a_host_valid = 1'b0;
        check("t5_level_same", 32'(a_level), 1);
        #1;
        check("t5_new_head", 32'(a_uart_ch), 32'h5A);
        tick();
        check("t5_level0", 32'(a_level), 0);
        // Last entry gone: next request starves
        #1;
        check("t5_starve_ch", 32'(a_uart_ch), 32'hFF);
        tick();
        a_uart_valid = 1'b0;
        check("t5_starve_cnt", a_starve, 1);

        // 8'hFF queued as data is delivered, not counted as starve
        a_push(8'hFF);
        a_uart_valid = 1'b1;
        #1;
        check("ff_data_ch", 32'(a_uart_ch), 32'hFF);
        tick();
        a_uart_valid = 1'b0;
        check("ff_data_starve", a_starve, 1);
        check("ff_data_level",  32'(a_level), 0);

        // Test 6: reset with level 5 discards everything
        for (int i = 0; i < 5; i++) begin
            a_push(8'h70 + 8'(i));
        end
        check("t6_level5", 32'(a_level), 5);
        do_reset();
        check("t6_level0", 32'(a_level), 0);
        check("t6_starve0", a_starve, 0);
        check("t6_ready", 32'(a_host_ready), 1);
        a_uart_valid = 1'b1;
        #1;
        check("t6_ch", 32'(a_uart_ch), 32'hFF);
        tick();
        a_uart_valid = 1'b0;

        // Test 4: GAP=2, two bytes, request every cycle
        b_host_valid = 1'b1;
        b_host_ch    = 8'h61;
        tick();
        b_host_ch    = 8'h62;
        tick();
        b_host_valid = 1'b0;
        check("t4_level2", 32'(b_level), 2);
        b_uart_valid = 1'b1;
        #1;
        check("t4_ch0", 32'(b_uart_ch), 32'h61);
        tick();
        check("t4_ch1", 32'(b_uart_ch), 32'hFF);
        tick();
        check("t4_ch2", 32'(b_uart_ch), 32'hFF);
        tick();
        check("t4_ch3", 32'(b_uart_ch), 32'h62);
        tick();
        check("t4_starve2", 32'(b_starve), 2);
        check("t4_level0", 32'(b_level), 0);
        // Two more starves: the 2-bit counter saturates at 3
        tick();
        tick();
        b_uart_valid = 1'b0;
        check("t4_starve_sat", 32'(b_starve), 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
